// File: rtl/video_pkg.sv
// video_pkg: shared VRAM types and constants for the video frame latch
package video_pkg;
    typedef logic [7:0] vram_addr_t;
    typedef logic [3:0] vram_nibble_t;
    localparam vram_addr_t VRAM_ENTRIES    = 8'd160;
    localparam vram_addr_t VRAM_LAST       = 8'd159;
    localparam vram_addr_t VRAM_BANK1_BASE = 8'h50;
    typedef enum logic [1:0] {CLEAR, IDLE, COPY, DRAIN} frame_latch_state_t;
endpackage

// File: rtl/shadow_ram_2x160x4.sv
// shadow_ram_2x160x4: two 160x4 shadow banks, one write port, one registered read port
module shadow_ram_2x160x4
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       reset_i,
    input  logic       we_i,
    input  logic       wr_both_i,
    input  logic       wr_sel_i,
    input  logic [7:0] wr_addr_i,
    input  logic [3:0] wr_data_i,
    input  logic       rd_sel_i,
    input  logic [7:0] rd_addr_i,
    output logic [3:0] rd_data_o
);
    vram_nibble_t mem0_q [VRAM_ENTRIES];
    vram_nibble_t mem1_q [VRAM_ENTRIES];
    vram_nibble_t rd0_q, rd1_q;
    logic         sel_q, zero_q;
    // array writes kept free of reset so each bank maps onto a block RAM
    always_ff @(posedge clk) begin
        if (we_i && (wr_both_i || !wr_sel_i)) mem0_q[wr_addr_i] <= wr_data_i;
        if (we_i && (wr_both_i ||  wr_sel_i)) mem1_q[wr_addr_i] <= wr_data_i;
        rd0_q <= mem0_q[rd_addr_i];
        rd1_q <= mem1_q[rd_addr_i];
    end
    // bank select and zero forcing travel alongside the registered read
    always_ff @(posedge clk) begin
        sel_q  <= rd_sel_i;
        zero_q <= reset_i || (rd_addr_i >= VRAM_ENTRIES);
    end
    assign rd_data_o = zero_q ? 4'h0 : (sel_q ? rd1_q : rd0_q);
endmodule

// File: rtl/video_frame_latch.sv
// video_frame_latch: vsync-triggered double-buffered snapshot of CPU VRAM for scan-out
module video_frame_latch
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       freeze,
    output logic [7:0] src_addr,
    input  logic [3:0] src_data,
    input  logic [7:0] video_addr,
    output logic [3:0] video_data,
    output logic       busy,
    output logic       front_sel
);
    frame_latch_state_t state_q, state_d;
    vram_addr_t         wr_ptr_q, wr_ptr_d, src_q, src_d, pa_q, pa_d, mem_waddr;
    vram_nibble_t       mem_wdata;
    logic               front_q, front_d, bv_q, bv_d, wr_sel_q, wr_sel_d, pv_q, pv_d;
    logic               start, mem_we, mem_both;
    // next-state, capture pipe and write-port steering
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        front_d   = front_q;
        bv_d      = bv_q;
        wr_sel_d  = wr_sel_q;
        src_d     = src_q;
        pv_d      = 1'b0;
        pa_d      = src_q;
        start     = vsync && !freeze;
        mem_we    = 1'b0;
        mem_both  = 1'b0;
        mem_waddr = pa_q;
        mem_wdata = src_data;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_both  = 1'b1;
                mem_waddr = wr_ptr_q;
                mem_wdata = 4'h0;
                wr_ptr_d  = (wr_ptr_q == VRAM_LAST) ? wr_ptr_q : wr_ptr_q + 8'd1;
                state_d   = (wr_ptr_q == VRAM_LAST) ? IDLE : CLEAR;
            end
            IDLE: if (start) begin
                front_d  = front_q ^ bv_q;
                bv_d     = 1'b0;
                wr_sel_d = ~(front_q ^ bv_q);
                src_d    = 8'd0;
                state_d  = COPY;
            end
            COPY: begin
                mem_we  = pv_q && !start;
                pv_d    = !start;
                src_d   = start ? 8'd0 : ((src_q == VRAM_LAST) ? src_q : src_q + 8'd1);
                state_d = (!start && src_q == VRAM_LAST) ? DRAIN : COPY;
            end
            DRAIN: begin
                mem_we  = pv_q && !start;
                bv_d    = !start;
                src_d   = start ? 8'd0 : src_q;
                state_d = start ? COPY : IDLE;
            end
        endcase
    end
    // state register with synchronous reset back into CLEAR
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CLEAR;
            wr_ptr_q <= 8'd0;
            front_q  <= 1'b0;
            bv_q     <= 1'b0;
            wr_sel_q <= 1'b0;
            src_q    <= 8'd0;
            pv_q     <= 1'b0;
            pa_q     <= 8'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            front_q  <= front_d;
            bv_q     <= bv_d;
            wr_sel_q <= wr_sel_d;
            src_q    <= src_d;
            pv_q     <= pv_d;
            pa_q     <= pa_d;
        end
    end
    shadow_ram_2x160x4 u_ram (
        .clk       (clk),
        .reset_i   (reset),
        .we_i      (mem_we),
        .wr_both_i (mem_both),
        .wr_sel_i  (wr_sel_q),
        .wr_addr_i (mem_waddr),
        .wr_data_i (mem_wdata),
        .rd_sel_i  (front_q),
        .rd_addr_i (video_addr),
        .rd_data_o (video_data)
    );
    assign src_addr  = src_q;
    assign busy      = state_q != IDLE;
    assign front_sel = front_q;
endmodule

// File: tb/tb_video_frame_latch.sv
// tb_video_frame_latch: randomized self-checking bench against a frame-level model
module tb_video_frame_latch;
    logic       clk = 1'b0, reset = 1'b1, vsync = 1'b0, freeze = 1'b0;
    logic [7:0] src_addr, video_addr = 8'd0;
    logic [3:0] src_data = 4'h0, video_data;
    logic       busy, front_sel;
    logic [3:0] src_mem [160];
    logic [3:0] m_sh [2][160];
    int         m_clr = 0, m_cap = 0, m_src = 0;
    bit         m_front = 0, m_bv = 0, m_tgt = 0, m_vd_ok = 0;
    logic [3:0] m_vd = 4'h0;
    int         checks = 0, failures = 0;

    video_frame_latch dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .freeze     (freeze),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .video_addr (video_addr),
        .video_data (video_data),
        .busy       (busy),
        .front_sel  (front_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) src_data <= (src_addr < 8'd160) ? src_mem[src_addr] : 4'h0;

    task automatic tick();
        @(posedge clk);
        m_vd_ok = reset || m_clr == 0;
        m_vd = (reset || video_addr >= 8'd160) ? 4'h0 : m_sh[m_front][video_addr];
        if (reset) begin
            m_clr = 160; m_cap = 0; m_src = 0; m_front = 0; m_bv = 0;
            for (int a = 0; a < 160; a++) begin m_sh[0][a] = 4'h0; m_sh[1][a] = 4'h0; end
        end else if (m_clr > 0) begin
            m_clr--;
        end else if (vsync && !freeze) begin
            if (m_cap == 0 && m_bv) begin m_front = !m_front; m_bv = 0; end
            m_tgt = !m_front; m_cap = 161; m_src = 0;
        end else if (m_cap > 0) begin
            m_cap--;
            m_src = (161 - m_cap > 159) ? 159 : 161 - m_cap;
            if (m_cap == 0) begin
                for (int a = 0; a < 160; a++) m_sh[m_tgt][a] = src_mem[a];
                m_bv = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%0b exp=1", busy); end
        checks++; if (video_data !== 4'h0) begin failures++; $display("FAIL reset_video_data got=%0h exp=0", video_data); end
        checks++; if (src_addr !== 8'd0) begin failures++; $display("FAIL reset_src_addr got=%0d exp=0", src_addr); end
        checks++; if (front_sel !== 1'b0) begin failures++; $display("FAIL reset_front_sel got=%0b exp=0", front_sel); end
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy) n++;
            tick();
        end
        checks++; if (n != 160) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=160", n); end
        for (int a = 0; a < 160; a++) begin
            video_addr = 8'(a);
            tick();
            checks++; if (video_data !== m_vd) begin failures++; $display("FAIL clear_read addr=%0d got=%0h exp=%0h", a, video_data, m_vd); end
        end
        video_addr = 8'd200;
        tick();
        checks++; if (video_data !== 4'h0) begin failures++; $display("FAIL read_out_of_range got=%0h exp=0", video_data); end
    endtask

    task automatic test_first_capture();
        for (int a = 0; a < 160; a++) src_mem[a] = 4'(a);
        vsync = 1'b1; tick(); vsync = 1'b0;
        repeat (170) tick();
        checks++; if (front_sel !== m_front) begin failures++; $display("FAIL first_no_swap got=%0b exp=%0b", front_sel, m_front); end
        video_addr = 8'h53;
        tick();
        checks++; if (video_data !== m_vd) begin failures++; $display("FAIL first_still_blank got=%0h exp=%0h", video_data, m_vd); end
        for (int a = 0; a < 160; a++) src_mem[a] = ~4'(a);
        vsync = 1'b1; tick(); vsync = 1'b0;
        checks++; if (front_sel !== m_front) begin failures++; $display("FAIL second_swap got=%0b exp=%0b", front_sel, m_front); end
        tick();
        checks++; if (video_data !== m_vd) begin failures++; $display("FAIL swap_read_53 got=%0h exp=%0h", video_data, m_vd); end
    endtask

    task automatic test_hold_across_frames();
        video_addr = 8'h05;
        repeat (165) begin
            tick();
            checks++; if (video_data !== m_vd) begin failures++; $display("FAIL hold_read got=%0h exp=%0h", video_data, m_vd); end
        end
        vsync = 1'b1; tick(); vsync = 1'b0;
        checks++; if (video_data !== m_vd) begin failures++; $display("FAIL hold_swap_edge got=%0h exp=%0h", video_data, m_vd); end
        tick();
        checks++; if (video_data !== m_vd) begin failures++; $display("FAIL hold_after_swap got=%0h exp=%0h", video_data, m_vd); end
    endtask

    task automatic test_abort();
        vsync = 1'b1; tick(); vsync = 1'b0;
        checks++; if (front_sel !== m_front) begin failures++; $display("FAIL abort_first_front got=%0b exp=%0b", front_sel, m_front); end
        repeat (50) tick();
        vsync = 1'b1; tick(); vsync = 1'b0;
        checks++; if (front_sel !== m_front) begin failures++; $display("FAIL abort_second_front got=%0b exp=%0b", front_sel, m_front); end
        checks++; if (src_addr !== 8'(m_src)) begin failures++; $display("FAIL abort_restart_addr got=%0d exp=%0d", src_addr, m_src); end
        for (int i = 1; i <= 164; i++) begin
            tick();
            checks++; if (busy !== (m_cap > 0)) begin failures++; $display("FAIL abort_busy cycle=%0d got=%0b exp=%0b", i, busy, m_cap > 0); end
            checks++; if (src_addr !== 8'(m_src)) begin failures++; $display("FAIL abort_src cycle=%0d got=%0d exp=%0d", i, src_addr, m_src); end
        end
        vsync = 1'b1; tick(); vsync = 1'b0;
        checks++; if (front_sel !== m_front) begin failures++; $display("FAIL abort_then_swap got=%0b exp=%0b", front_sel, m_front); end
        repeat (165) tick();
    endtask

    task automatic test_freeze();
        freeze = 1'b1; vsync = 1'b1; tick(); vsync = 1'b0;
        checks++; if (front_sel !== m_front) begin failures++; $display("FAIL freeze_front got=%0b exp=%0b", front_sel, m_front); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL freeze_busy got=%0b exp=0", busy); end
        checks++; if (src_addr !== 8'(m_src)) begin failures++; $display("FAIL freeze_src got=%0d exp=%0d", src_addr, m_src); end
        freeze = 1'b0; vsync = 1'b1; tick(); vsync = 1'b0;
        checks++; if (front_sel !== m_front) begin failures++; $display("FAIL unfreeze_swap got=%0b exp=%0b", front_sel, m_front); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL unfreeze_busy got=%0b exp=1", busy); end
        repeat (20) tick();
        freeze = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tick();
            checks++; if (busy !== (m_cap > 0)) begin failures++; $display("FAIL freeze_mid_copy_busy got=%0b exp=%0b", busy, m_cap > 0); end
        end
        freeze = 1'b0; vsync = 1'b1; tick(); vsync = 1'b0;
        checks++; if (front_sel !== m_front) begin failures++; $display("FAIL freeze_mid_copy_swap got=%0b exp=%0b", front_sel, m_front); end
    endtask

    task automatic test_random();
        for (int a = 0; a < 160; a++) src_mem[a] = 4'($urandom);
        for (int i = 0; i < 1500; i++) begin
            vsync = ($urandom_range(0, 199) == 0);
            freeze = ($urandom_range(0, 3) == 0);
            video_addr = 8'($urandom_range(0, 180));
            if (m_cap == 0 && $urandom_range(0, 9) == 0) src_mem[$urandom_range(0, 159)] = 4'($urandom);
            tick();
            if (m_vd_ok) begin
                checks++; if (video_data !== m_vd) begin failures++; $display("FAIL rand_read addr=%0d got=%0h exp=%0h", video_addr, video_data, m_vd); end
            end
            checks++; if (front_sel !== m_front) begin failures++; $display("FAIL rand_front got=%0b exp=%0b", front_sel, m_front); end
            checks++; if (busy !== (m_cap > 0)) begin failures++; $display("FAIL rand_busy got=%0b exp=%0b", busy, m_cap > 0); end
            checks++; if (src_addr !== 8'(m_src)) begin failures++; $display("FAIL rand_src got=%0d exp=%0d", src_addr, m_src); end
        end
        vsync = 1'b0; freeze = 1'b0;
        repeat (170) tick();
    endtask

    task automatic test_reset_mid_copy();
        int n;
        vsync = 1'b1; tick(); vsync = 1'b0;
        repeat (80) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (front_sel !== 1'b0) begin failures++; $display("FAIL midreset_front got=%0b exp=0", front_sel); end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy) n++;
            tick();
        end
        checks++; if (n != 160) begin failures++; $display("FAIL midreset_clear_cycles got=%0d exp=160", n); end
        for (int a = 0; a < 160; a++) begin
            video_addr = 8'(a);
            tick();
            checks++; if (video_data !== m_vd) begin failures++; $display("FAIL midreset_read addr=%0d got=%0h exp=%0h", a, video_data, m_vd); end
        end
    endtask

    initial begin
        for (int a = 0; a < 160; a++) src_mem[a] = 4'h0;
        test_reset();
        test_first_capture();
        test_hold_across_frames();
        test_abort();
        test_freeze();
        test_random();
        test_reset_mid_copy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
